// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// Module : if_id_queue_pkg
// Brief  : Shared defaults and constants for the IF/ID bundle queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_id_queue_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned LANES_DEF = 2;
    localparam int unsigned DEPTH_DEF = 4;

    // NOP bubble encoding; wide enough for any supported XLEN (up to 64).
    localparam logic [63:0] NOP_INSTR = 64'h0;

endpackage

`default_nettype wire

// File: rtl/if_id_qctrl.sv
// ============================================================================
// Module : if_id_qctrl
// Brief  : Head/tail pointer and occupancy control for the IF/ID bundle queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_qctrl
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module : if_id_queue
// Brief  : Fetch-to-decode bundle FIFO with per-lane NOP masking and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [LANES*XLEN-1:0]      in_instr,
    input  logic [LANES-1:0]           in_lane_valid,
    input  logic [31:0]                in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [LANES*XLEN-1:0]      out_instr,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Storage is deliberately not reset; output masking hides stale words.
    logic [LANES*XLEN-1:0] instr_mem [DEPTH];
    logic [LANES-1:0]      lv_mem    [DEPTH];
    logic [31:0]           pc_mem    [DEPTH];

    logic [LANES*XLEN-1:0] head_instr;
    logic [LANES-1:0]      head_lv;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    if_id_qctrl #(
        .DEPTH (DEPTH)
    ) u_qctrl (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= in_instr;
            lv_mem[tail]    <= in_lane_valid;
            pc_mem[tail]    <= in_pc;
        end
    end

    assign head_instr     = instr_mem[head];
    assign head_lv        = lv_mem[head];
    assign out_lane_valid = out_valid ? head_lv : '0;
    assign out_pc         = out_valid ? pc_mem[head] : 32'h0;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign out_instr[l*XLEN +: XLEN] = out_lane_valid[l] ? head_instr[l*XLEN +: XLEN]
                                                             : NOP_INSTR[XLEN-1:0];
    end

endmodule

`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction word width in bits.
REQ-002 Parameter LANES, default 2, instructions per fetch bundle; legal range 1..4.
REQ-003 Parameter DEPTH, default 4, bundle entries; power of two, legal range 2..16.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  fetch presents a bundle this cycle.
REQ-007 Port in_instr  input  LANES*XLEN  bundle words; lane 0 in the least-significant XLEN bits.
REQ-008 Port in_lane_valid  input  LANES  per-lane valid mask for the bundle.
REQ-009 Port in_pc  input  32  PC of lane 0 of the bundle.
REQ-010 Port in_ready  output  1  queue accepts a bundle this cycle.
REQ-011 Port out_valid  output  1  head bundle available to decode.
REQ-012 Port out_instr  output  LANES*XLEN  head bundle words.
REQ-013 Port out_lane_valid  output  LANES  head bundle lane mask.
REQ-014 Port out_pc  output  32  head bundle PC.
REQ-015 Port out_ready  input  1  decode consumes the head bundle this cycle.
REQ-016 Port flush  input  1  discard all queued bundles.
REQ-017 Port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Enqueue occurs when in_valid && in_ready && !flush; the bundle is written at the tail and the tail pointer advances by one, modulo DEPTH.
REQ-019 Dequeue occurs when out_valid && out_ready && !flush; the head pointer advances by one, modulo DEPTH.
REQ-020 in_ready = (count < DEPTH); it does not depend on out_ready, so there is no same-cycle pass-through when the queue is full.
REQ-021 out_valid = (count != 0); out_* reflect the head entry combinationally from storage, giving one cycle of enqueue-to-output latency.
REQ-022 When out_valid=0, out_instr, out_lane_valid and out_pc read as all zeros (NOP bubble).
REQ-023 For every lane whose out_lane_valid bit is 0, the corresponding out_instr field reads as zero, whatever is stored.
REQ-024 A bundle with in_valid=1 and in_lane_valid=0 is enqueued normally and occupies one entry.
REQ-025 count updates as +1 for enqueue only, -1 for dequeue only, and no change for both or neither.
REQ-026 Simultaneous enqueue and dequeue at count=DEPTH is impossible because in_ready=0; at count=0, out_valid=0, so only the enqueue takes effect.
REQ-027 flush=1 sets head=tail=0 and count=0 at the next edge, overriding any enqueue or dequeue in that cycle; out_valid=0 in the following cycle.
REQ-028 Stall is expressed by out_ready=0; the head holds stable and unchanged while out_valid=1 and out_ready=0.
REQ-029 Pointer wrap-around keeps FIFO order; after any sequence of operations, the dequeue order equals the enqueue order.

Reset
REQ-030 reset=0 immediately clears head, tail and count to 0, so out_valid=0, in_ready=1 and all out_* read as zero.
REQ-031 Storage contents need not be reset; the masking in REQ-022 guarantees zero outputs.
REQ-032 Reset asserted mid-operation discards all entries; the first bundle after reset release appears as the head.

Structure
REQ-033 A shared package holds the defaults for XLEN, LANES and DEPTH, plus the NOP encoding constant (all zeros).
REQ-034 Pointer and count arithmetic live in one natural sub-module, if_id_qctrl (head, tail, count, full and empty); the storage array and output masking stay in if_id_queue.

Verification
REQ-035 With defaults, enqueue bundles with PCs 0x100, 0x108, 0x110, 0x118 and out_ready=0 -> count=4, in_ready=0, out_pc=0x100.
REQ-036 From full, set out_ready=1 and in_valid=1 (PC 0x120) for one cycle -> dequeue only, count=3, out_pc=0x108.
REQ-037 Enqueue 10 bundles with continuous out_ready=1 -> out_pc sequence in order with no loss across wrap; count never exceeds 1.
REQ-038 With count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=0.
REQ-039 Enqueue in_instr={0xDEADBEEF, 0x00A00093} with in_lane_valid=2'b01 -> out_instr upper lane=0, lower lane=0x00A00093.
REQ-040 Drive reset low asynchronously between edges with count=2 -> count=0 and out_valid=0 immediately; after release, the first enqueued bundle becomes the head.
